// File: rtl/updn_counter.sv
// Up/down counter with parallel load, cascade carry, wrap-or-saturate at a
// programmable terminal count and a sticky overflow flag.
module updn_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = '1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             CI,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             step;
  logic             term;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_next;

  assign step    = EN & CI & ~LOAD;
  assign at_max  = (Q == MAX);
  assign at_zero = (Q == '0);
  assign term    = UP ? at_max : at_zero;

  // CO is combinational so a cascaded stage advances on the same edge.
  assign CO   = step & term;
  assign ZERO = at_zero;

  // Loads above the terminal count are clamped so Q never exceeds MAX.
  assign load_val = (D > MAX) ? MAX : D;

  always_comb begin
    // NOTE: q_next gets a default before any branch so no path leaves it unassigned (no latch).
    q_next = Q;
    if (LOAD) begin
      q_next = load_val;
    end else if (step) begin
      if (!term) begin
        q_next = UP ? Q + ONE : Q - ONE;
      end else if (!SATURATE) begin
        q_next = UP ? '0 : MAX;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Q   <= '0;
      OVF <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      Q <= q_next;
      // A terminal step beats a simultaneous clear; LOAD never touches OVF.
      if (CO) begin
        OVF <= 1'b1;
      end else if (CLR_OVF) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updn_counter.sv
// Scoreboard bench: a driver pushes model predictions per cycle, a monitor
// pops and compares them against wrap, saturate and cascaded instances.
module tb_updn_counter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       casc_rst_n = 1'b0;
  logic       EN = 1'b0, CI = 1'b0, UP = 1'b0, LOAD = 1'b0, CLR_OVF = 1'b0;
  logic [3:0] D = '0;
  logic       casc_en = 1'b0;

  logic [3:0] q_w, q_s, q_lo, q_hi;
  logic       co_w, co_s, co_lo, co_hi;
  logic       ovf_w, ovf_s, ovf_lo, ovf_hi;
  logic       zero_w, zero_s, zero_lo, zero_hi;

  always #5 CLK = ~CLK;

  updn_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .CI(CI), .UP(UP), .LOAD(LOAD),
    .D(D), .CLR_OVF(CLR_OVF), .Q(q_w), .CO(co_w), .OVF(ovf_w), .ZERO(zero_w));

  updn_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) dut_s (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .CI(CI), .UP(UP), .LOAD(LOAD),
    .D(D), .CLR_OVF(CLR_OVF), .Q(q_s), .CO(co_s), .OVF(ovf_s), .ZERO(zero_s));

  updn_counter #(.WIDTH(4), .MAX(4'd15), .SATURATE(1'b0)) dut_lo (
    .CLK(CLK), .RESET_N(casc_rst_n), .EN(casc_en), .CI(1'b1), .UP(1'b1),
    .LOAD(1'b0), .D(4'd0), .CLR_OVF(1'b0), .Q(q_lo), .CO(co_lo), .OVF(ovf_lo),
    .ZERO(zero_lo));

  updn_counter #(.WIDTH(4), .MAX(4'd15), .SATURATE(1'b0)) dut_hi (
    .CLK(CLK), .RESET_N(casc_rst_n), .EN(casc_en), .CI(co_lo), .UP(1'b1),
    .LOAD(1'b0), .D(4'd0), .CLR_OVF(1'b0), .Q(q_hi), .CO(co_hi), .OVF(ovf_hi),
    .ZERO(zero_hi));

  typedef struct {
    logic [3:0] q_w, q_s;
    logic       ovf_w, ovf_s, co_w, co_s, zero_w, zero_s;
    logic [7:0] casc_q;
    logic       casc_ovf_lo, casc_ovf_hi, casc_co_lo, casc_co_hi;
    logic       casc_zero_lo, casc_zero_hi;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integers, counter range 0..9 for the main pair.
  int mq_w = 0, mq_s = 0, m_cnt = 0;
  bit mo_w = 0, mo_s = 0, m_ovf_lo = 0, m_ovf_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next count/flag from the behavioural rules for a terminal count of 9.
  function automatic void model_next(input int q, input bit ovf, input bit sat,
                                     input bit en, input bit ci, input bit up,
                                     input bit load, input int d, input bit clr,
                                     output int nq, output bit novf, output bit co);
    bit step, term;
    step = en && ci && !load;
    term = up ? (q == 9) : (q == 0);
    co   = step && term;
    nq   = q;
    novf = ovf;
    if (load)                 nq = (d > 9) ? 9 : d;
    else if (step && !term)   nq = up ? q + 1 : q - 1;
    else if (step && !sat)    nq = up ? 0 : 9;
    if (co)       novf = 1'b1;
    else if (clr) novf = 1'b0;
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit ci, input bit up,
                       input bit load, input int d, input bit clr,
                       input bit cen, input bit crst);
    exp_t e;
    int   nq;
    bit   no, co;
    @(posedge CLK);
    #1;
    RESET_N = rst; EN = en; CI = ci; UP = up; LOAD = load; D = 4'(d);
    CLR_OVF = clr; casc_en = cen; casc_rst_n = crst;
    if (!rst) begin
      mq_w = 0; mq_s = 0; mo_w = 0; mo_s = 0;
    end
    if (!crst) begin
      m_cnt = 0; m_ovf_lo = 0; m_ovf_hi = 0;
    end
    e.q_w = 4'(mq_w); e.ovf_w = mo_w; e.zero_w = (mq_w == 0);
    model_next(mq_w, mo_w, 1'b0, en, ci, up, load, d, clr, nq, no, co);
    e.co_w = co;
    if (rst) begin mq_w = nq; mo_w = no; end
    e.q_s = 4'(mq_s); e.ovf_s = mo_s; e.zero_s = (mq_s == 0);
    model_next(mq_s, mo_s, 1'b1, en, ci, up, load, d, clr, nq, no, co);
    e.co_s = co;
    if (rst) begin mq_s = nq; mo_s = no; end
    e.casc_q       = 8'(m_cnt % 256);
    e.casc_ovf_lo  = m_ovf_lo;
    e.casc_ovf_hi  = m_ovf_hi;
    e.casc_co_lo   = cen && (m_cnt % 16 == 15);
    e.casc_co_hi   = cen && (m_cnt % 256 == 255);
    e.casc_zero_lo = (m_cnt % 16 == 0);
    e.casc_zero_hi = ((m_cnt / 16) % 16 == 0);
    if (crst && cen) begin
      if (m_cnt % 16 == 15)   m_ovf_lo = 1'b1;
      if (m_cnt % 256 == 255) m_ovf_hi = 1'b1;
      m_cnt++;
    end
    sb.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wrap_q",    32'(q_w),    32'(e.q_w));
        check("wrap_ovf",  32'(ovf_w),  32'(e.ovf_w));
        check("wrap_co",   32'(co_w),   32'(e.co_w));
        check("wrap_zero", 32'(zero_w), 32'(e.zero_w));
        check("sat_q",     32'(q_s),    32'(e.q_s));
        check("sat_ovf",   32'(ovf_s),  32'(e.ovf_s));
        check("sat_co",    32'(co_s),   32'(e.co_s));
        check("sat_zero",  32'(zero_s), 32'(e.zero_s));
        check("casc_q",       32'({q_hi, q_lo}), 32'(e.casc_q));
        check("casc_ovf_lo",  32'(ovf_lo),  32'(e.casc_ovf_lo));
        check("casc_ovf_hi",  32'(ovf_hi),  32'(e.casc_ovf_hi));
        check("casc_co_lo",   32'(co_lo),   32'(e.casc_co_lo));
        check("casc_co_hi",   32'(co_hi),   32'(e.casc_co_hi));
        check("casc_zero_lo", 32'(zero_lo), 32'(e.casc_zero_lo));
        check("casc_zero_hi", 32'(zero_hi), 32'(e.casc_zero_hi));
      end
    end
  end

  initial begin
    int drain;
    // Held in reset with UP=0, EN=CI=1: CO should equal step, ZERO=1.
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
    // Up wrap: 0..9,0,1 with OVF from the edge leaving 9.
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 1, 0, 0, 0, 0, 0);
    // OVF race: set wins over clear, then clear alone.
    cycle(1, 0, 1, 1, 1, 9, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0);
    // Load clamp and priority over a pending step.
    cycle(1, 0, 1, 1, 1, 5, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 13, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0);
    // Down run through zero: saturate holds, wrap reloads MAX.
    cycle(1, 0, 1, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Direction change takes effect on the very next step.
    cycle(1, 1, 1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Async reset between edges with Q=7, then resume from 0.
    cycle(1, 0, 1, 1, 1, 7, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 1, 0, 0, 0, 0, 0);
    // Random traffic; cascade runs for exactly 300 enabled cycles.
    for (int i = 0; i < 400; i++) begin
      cycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
            i < 300, 1);
    end
    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge CLK);
      #1;
      drain++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    check("casc_300_q",   32'({q_hi, q_lo}), 32'd44);
    check("casc_300_ovf", 32'(ovf_hi), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
